// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial word deserializer.
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam string DIR_LEFT  = "left";
    localparam string DIR_RIGHT = "right";

    // Bit counter must hold 0..w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/deser_shift_core.sv
// Shift register plus bit counter. `word` is the register contents including the
// bit being shifted this cycle, so the top can capture a completed word on the same edge.
module deser_shift_core
    import serial_pkg::*;
#(
    parameter int W         = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load0,
    input  logic         shift,
    input  logic         SI,
    output logic [W-1:0] word,
    output logic         done
);

    localparam int CW = cnt_width(W);

    logic [W-1:0]  sr;
    logic [CW-1:0] cnt;
    logic [W-1:0]  seeded;
    logic [W-1:0]  shifted;

    generate
        if (MSB_FIRST) begin : g_msb
            assign seeded  = {{(W-1){1'b0}}, SI};
            assign shifted = {sr[W-2:0], SI};
        end else begin : g_lsb
            assign seeded  = {SI, {(W-1){1'b0}}};
            assign shifted = {SI, sr[W-1:1]};
        end
    endgenerate

    assign done = shift && (cnt == CW'(W - 1));
    assign word = shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load0) begin
            sr  <= seeded;
            cnt <= CW'(1);
        end else if (shift) begin
            sr  <= shifted;
            cnt <= done ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/serial_word_deserializer.sv
// Framed serial-to-parallel receiver with a one-entry valid/ready output buffer,
// sticky overrun and a one-cycle frame error pulse. Legal w is 2..32.
module serial_word_deserializer
    import serial_pkg::*;
#(
    parameter int    w               = 4,
    parameter string shift_direction = "left"
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sclr,
    input  logic         SI,
    input  logic         en,
    input  logic         sof,
    output logic [w-1:0] q,
    output logic         q_valid,
    input  logic         q_ready,
    output logic         busy,
    output logic         overrun,
    output logic         frame_err
);

    localparam bit MSB_FIRST = (shift_direction != DIR_RIGHT);

    state_t       state;
    logic         load0;
    logic         shift_bit;
    logic         done;
    logic [w-1:0] word;

    // A sof always restarts the word, whether from IDLE or mid-word.
    assign load0     = !sclr && en && sof;
    assign shift_bit = !sclr && en && !sof && (state == SHIFT);

    deser_shift_core #(
        .W        (w),
        .MSB_FIRST(MSB_FIRST)
    ) u_core (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (sclr),
        .load0(load0),
        .shift(shift_bit),
        .SI   (SI),
        .word (word),
        .done (done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            q         <= '0;
            q_valid   <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else if (sclr) begin
            state     <= IDLE;
            busy      <= 1'b0;
            q_valid   <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && sof) begin
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (en && sof) begin
                        frame_err <= 1'b1;
                    end else if (done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // A word completing while the buffer drains this cycle is still accepted.
            if (done) begin
                if (!q_valid || q_ready) begin
                    q       <= word;
                    q_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (q_valid && q_ready) begin
                q_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/serial_word_deserializer.md
# serial_word_deserializer

Receive-side counterpart to the team's parameterized shift register used as a serial transmitter. Samples a framed serial bit stream (one bit per `en` strobe, first bit of each word flagged by `sof`), assembles `w`-bit words in the configured bit order, and presents each completed word through a one-entry valid/ready output buffer. Sits between the serial link and the parallel consumer; reports overrun and framing errors.

## Interface
- `w`, default 4: word width in bits; legal range 2..32.
- `shift_direction`, default "left": "left" means MSB first, so the first received bit lands in `q[w-1]`; "right" means LSB first, so the first received bit lands in `q[0]`.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `sclr` input 1: synchronous clear; highest synchronous priority.
- `SI` input 1: serial data bit; sampled only when `en`=1.
- `en` input 1: bit strobe; one data bit per cycle with `en`=1.
- `sof` input 1: start of frame; meaningful only with `en`=1; marks that bit as bit 0 of a word.
- `q` output w: received word; stable while `q_valid`=1.
- `q_valid` output 1: `q` holds an unconsumed word.
- `q_ready` input 1: consumer accepts `q` when `q_valid`&`q_ready`.
- `busy` output 1: a word is partially received (state SHIFT).
- `overrun` output 1: sticky; a completed word was dropped because the buffer was full.
- `frame_err` output 1: one-cycle pulse; a partial word was abandoned by a new `sof`.

## Operation
- States:
  - IDLE: no partial word.
  - SHIFT: collecting; bit counter `cnt` ranges 1..w-1.
- IDLE:
  - `en`&`sof`: store `SI` as bit 0, set `cnt`=1, go to SHIFT.
  - `en` without `sof`: ignore the bit; stay in IDLE.
- SHIFT, `en`&!`sof`: shift `SI` in and increment `cnt`.
  - The bit that makes `cnt` reach w completes the word. Return to IDLE; the next word needs a new `sof`.
- SHIFT, `en`&`sof`: discard the partial word, pulse `frame_err`, and restart with this bit as bit 0 (`cnt`=1, stay in SHIFT).
- SHIFT, `en`=0: hold all state. There is no timeout.
- Completed word:
  - If `q_valid`=0, or `q_valid`&`q_ready` in the same cycle: load the word into `q` and set `q_valid`=1.
  - Otherwise: drop the word, keep `q` unchanged, and set `overrun`=1.
- Consume: `q_valid`&`q_ready` with no completion in that cycle clears `q_valid`. `q` keeps its last value.
- `sclr`=1:
  - Go to IDLE, `cnt`=0, clear `q_valid`, `overrun` and `frame_err`; `q` is not changed.
  - `en`, `sof` and `q_ready` are ignored that cycle.
- `overrun` is cleared only by `sclr` or `rst_n`.

## Timing
- Reset values: `q`=0, `q_valid`=0, `busy`=0, `overrun`=0, `frame_err`=0, state IDLE, `cnt`=0.
- Latency: `q_valid` rises on the edge that samples the w-th bit, so the word is visible in the following cycle. The minimum word period is w `en` cycles.
- `busy` is a registered copy of state==SHIFT.
- `frame_err` is high for exactly the one cycle after the offending `sof` edge.
- Back-to-back words at full rate (`en`=1 continuously, `sof` every w cycles) with `q_ready`=1 lose no words.
- An `rst_n` assertion mid-word abandons the word immediately and asynchronously. No `frame_err` is raised.

## Structure
- Shared package `serial_pkg`:
  - state enum {IDLE, SHIFT};
  - direction string constants DIR_LEFT / DIR_RIGHT;
  - function `cnt_width(w)` = $clog2(w+1).
- Sub-module `deser_shift_core`:
  - contains the shift register and bit counter;
  - inputs `clk`, `rst_n`, `clr`, `load0`, `shift`, `SI`;
  - outputs `word` and `done`.
- The top level holds the FSM, the output buffer and the flags.

## Test plan
- Reset check: hold `rst_n`=0 with random inputs, then release. Expect every output at 0 and `busy`=0.
- w=4, "left": send bits 1,1,0,1 with `sof` on the first bit. Expect `q`=4'b1101 and `q_valid`=1 one cycle after the 4th bit. Then `q_ready`=1 for one cycle; expect `q_valid`=0.
- w=4, "right": send the same bits 1,1,0,1. Expect `q`=4'b1011.
- Overrun: with `q_ready`=0, send two words, 1101 then 0110. Expect `q`=1101 still and `overrun`=1. Then `sclr` for one cycle; expect `overrun`=0 and `q_valid`=0.
- Resync: send `sof`+1, 0, then `sof`+0, 1, 1, 1. Expect a one-cycle `frame_err` after the second `sof` and `q`=4'b0111.
- Gaps and simultaneous events:
  - Insert `en`=0 gaps inside a word; expect the result unchanged.
  - Complete a word in the same cycle as `q_valid`&`q_ready`; expect the new word loaded and `overrun`=0.
  - Pulse `rst_n` low mid-word; expect IDLE and no `frame_err`.
